x_mem_responder: RTL and testbench
==================================

# x_mem_responder

Bus responder for the single-initiator memory interface driven by the RV32I core: valid/rnw/addr/data request, single-cycle accept, read data returned with accept. It serves a word-addressed RAM for instruction fetch, loads and stores, plus two memory-mapped peripheral words: a GPIO output register and a free-running cycle timer. A programmable wait-state count lets the bench stress the core's stall paths.

## Interface
- DEPTH_WORDS, 1024: RAM size in 32-bit words; power of two, 16..65536.
- WAIT, 1: wait-state cycles inserted before accept; 0..15.
- GPIO_ADDR, 32'h8000_0000: byte address of the GPIO register.
- TIMER_ADDR, 32'h8000_0004: byte address of the timer; read-only.
- INIT_FILE, "": hex image loaded into RAM at time zero in simulation; empty means no preload.

- i_clk  in  1  clock
- i_nrst  in  1  reset, synchronous, active-low
- i_valid  in  1  request present
- i_rnw  in  1  1 = read, 0 = write
- i_addr  in  32  byte address; bits [1:0] ignored
- i_data  in  32  write data
- o_accept  out  1  single-cycle completion pulse
- o_data  out  32  read data, valid only while o_accept = 1
- o_gpio  out  32  GPIO register contents
- o_err  out  1  sticky; set by any access to an unmapped address

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if i_valid = 1, latch i_addr, i_rnw and i_data. Load the wait counter with WAIT. Go to WAIT if WAIT > 0, else go to RESP.
- WAIT: decrement the counter each cycle. Go to RESP when the counter reads 1.
- RESP: o_accept = 1. Always return to IDLE next cycle. A request still present in IDLE is treated as a new transaction.
- Decode of the latched address:
  - GPIO_ADDR or TIMER_ADDR matches: peripheral word.
  - Otherwise, address < DEPTH_WORDS*4: RAM, index addr[2 +: log2(DEPTH_WORDS)].
  - Otherwise: unmapped.
- Read: o_data is combinational from the target during RESP. RAM word, o_gpio, or the current timer value. Unmapped returns 0.
- Write: committed at the clock edge ending RESP. RAM word or o_gpio is updated. Timer and unmapped writes are dropped.
- Unmapped access is still accepted, so the core never hangs, and it sets o_err.
- Timer: increments every cycle, including during reset release, and wraps 0xFFFF_FFFF -> 0. A read returns the value during the RESP cycle.
- All operations are full 32-bit words. There are no byte enables and no misalignment handling.

## Timing
- Reset (i_nrst = 0 at a clock edge):
  - State goes to IDLE; o_accept = 0; o_gpio = 0; o_err = 0; timer = 0.
  - o_data = 0 whenever not in RESP.
  - RAM contents are not reset.
- Reset mid-transaction: the transaction is abandoned. No write occurs and no accept is issued.
- Latency: request first seen in IDLE at cycle N gives o_accept at cycle N+1+WAIT. Throughput is one transaction per WAIT+2 cycles.
- The initiator holds i_valid, i_rnw, i_addr and i_data stable until accept. The responder uses only the latched copy.
- i_valid dropping before accept (protocol violation): the latched transaction still completes, including write commit and accept pulse.
- o_accept is never high on two consecutive cycles.

## Structure
- Package x_mem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - default GPIO_ADDR and TIMER_ADDR constants;
  - the address-decode result enum (RAM, GPIO, TIMER, UNMAPPED).
- Sub-module x_mem_array:
  - DEPTH_WORDS x 32 storage, one synchronous write port, one asynchronous read port;
  - INIT_FILE preload;
  - no reset.
- Top level holds the FSM, wait counter, request latch, decode, timer, GPIO register and error flag.

## Test plan
- Reset, WAIT=1: hold i_nrst=0 for 3 cycles -> o_accept=0, o_gpio=0, o_err=0, o_data=0. A timer read at the first transaction returns a small count consistent with cycles since reset.
- WAIT=0: write 0xDEAD_BEEF to 0x10, then read 0x10 -> each accept arrives 1 cycle after the request appears; the read returns 0xDEAD_BEEF.
- WAIT=3: back-to-back reads with i_valid held high and the address changing after each accept -> each accept arrives 4 cycles after the request; data matches the INIT_FILE words.
- GPIO: write 0x0000_00A5 to 0x8000_0000 -> o_gpio = 0xA5 the cycle after accept. A read back returns 0xA5. A write to 0x8000_0004 leaves the timer counting unchanged.
- Unmapped: read 0x4000_0000 -> accepted, o_data=0, and o_err rises and stays 1 until reset.
- Reset mid-operation: assert i_nrst=0 during WAIT of a write to 0x20 -> no accept and RAM[8] is unchanged. The next access completes normally.
- Integration: run the core against the responder with a program that stores and loads a loop counter -> the expected final value is visible in RAM and on o_gpio.

Source files
------------

// File: rtl/x_mem_pkg.sv
// Shared types and defaults for the x_mem_responder bus slave.
package x_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    DEC_RAM,
    DEC_GPIO,
    DEC_TIMER,
    DEC_UNMAPPED
  } dec_e;

  localparam logic [31:0] DEF_GPIO_ADDR  = 32'h8000_0000;
  localparam logic [31:0] DEF_TIMER_ADDR = 32'h8000_0004;

  // Word-granular decode: the two low address bits never take part.
  function automatic dec_e decode(input logic [31:0] addr,
                                  input logic [31:0] gpio_addr,
                                  input logic [31:0] timer_addr,
                                  input logic [31:0] ram_bytes);
    dec_e res;
    if (addr[31:2] == gpio_addr[31:2])                res = DEC_GPIO;
    else if (addr[31:2] == timer_addr[31:2])          res = DEC_TIMER;
    else if ({addr[31:2], 2'b00} < ram_bytes)         res = DEC_RAM;
    else                                              res = DEC_UNMAPPED;
    return res;
  endfunction

endpackage

// File: rtl/x_mem_array.sv
// Word RAM: one synchronous write port, one asynchronous read port.
module x_mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter     INIT_FILE   = "",
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: storage arrays carry no reset; clearing them would force a flop-based
  // implementation and contents are meaningful across reset anyway.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/x_mem_responder.sv
// Single-initiator memory responder: word RAM, GPIO register, free-running timer,
// programmable wait states and a sticky unmapped-access error flag.
module x_mem_responder
  import x_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT        = 1,
  parameter logic [31:0] GPIO_ADDR   = DEF_GPIO_ADDR,
  parameter logic [31:0] TIMER_ADDR  = DEF_TIMER_ADDR,
  parameter              INIT_FILE   = ""
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_valid,
  input  logic        i_rnw,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic        o_accept,
  output logic [31:0] o_data,
  output logic [31:0] o_gpio,
  output logic        o_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS) << 2;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        rnw_q, rnw_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] gpio_q, gpio_d;
  logic        err_q, err_d;

  dec_e        dec;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] rdata;

  assign dec = decode(addr_q, GPIO_ADDR, TIMER_ADDR, RAM_BYTES);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rnw_d   = rnw_q;
    gpio_d  = gpio_q;
    err_d   = err_q;
    timer_d = timer_q + 32'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          addr_d  = i_addr;
          data_d  = i_data;
          rnw_d   = i_rnw;
          cnt_d   = 4'(WAIT);
          state_d = (WAIT > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (!rnw_q && dec == DEC_GPIO) gpio_d = data_q;
        if (dec == DEC_UNMAPPED)       err_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The RAM has no reset of its own, so its write must be masked here to
  // abandon a transaction caught by reset on its final cycle.
  assign ram_we = i_nrst && (state_q == ST_RESP) && !rnw_q && (dec == DEC_RAM);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rnw_q   <= 1'b1;
      timer_q <= '0;
      gpio_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rnw_q   <= rnw_d;
      timer_q <= timer_d;
      gpio_q  <= gpio_d;
      err_q   <= err_d;
    end
  end

  x_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .i_clk  (i_clk),
    .i_we   (ram_we),
    .i_waddr(addr_q[2 +: AW]),
    .i_wdata(data_q),
    .i_raddr(addr_q[2 +: AW]),
    .o_rdata(ram_rdata)
  );

  always_comb begin
    rdata = '0;
    if (state_q == ST_RESP && rnw_q) begin
      unique case (dec)
        DEC_RAM:   rdata = ram_rdata;
        DEC_GPIO:  rdata = gpio_q;
        DEC_TIMER: rdata = timer_q;
        default:   rdata = '0;
      endcase
    end
  end

  assign o_accept = (state_q == ST_RESP);
  assign o_data   = rdata;
  assign o_gpio   = gpio_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_x_mem_responder.sv
// Scoreboard bench: three responders (WAIT 0/1/3), a spec-level memory model and
// a negedge monitor that checks every accept for data and latency.
module tb_x_mem_responder;

  localparam int          NI         = 3;
  localparam logic [31:0] GPIO_A     = 32'h8000_0000;
  localparam logic [31:0] TIMER_A    = 32'h8000_0004;
  localparam int          K_RAM      = 0;
  localparam int          K_GPIO     = 1;
  localparam int          K_TIMER    = 2;
  localparam int          K_UNMAPPED = 3;

  function automatic int wait_of(int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  function automatic int depth_of(int k);
    return (k == 2) ? 64 : 1024;
  endfunction

  logic                 clk = 1'b0;
  logic                 nrst;
  logic [NI-1:0]        valid, rnw, acc, err;
  logic [NI-1:0][31:0]  addr, wdata, rdata, gpio;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    x_mem_responder #(
      .DEPTH_WORDS((g == 2) ? 64 : 1024),
      .WAIT       ((g == 0) ? 0 : ((g == 1) ? 1 : 3)),
      .GPIO_ADDR  (GPIO_A),
      .TIMER_ADDR (TIMER_A),
      .INIT_FILE  ("")
    ) u_dut (
      .i_clk   (clk),
      .i_nrst  (nrst),
      .i_valid (valid[g]),
      .i_rnw   (rnw[g]),
      .i_addr  (addr[g]),
      .i_data  (wdata[g]),
      .o_accept(acc[g]),
      .o_data  (rdata[g]),
      .o_gpio  (gpio[g]),
      .o_err   (err[g])
    );
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  typedef struct {
    int          inst;
    int          id;
    bit          rnw;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];

  // Reference model: plain arrays indexed by instance and word.
  logic [31:0] ref_ram [int];
  logic [31:0] ref_gpio [NI];
  bit          ref_err  [NI];
  int          last_acc [NI];
  int          rst_cyc;
  int          txn_id = 0;

  function automatic int kind_of(int k, logic [31:0] a);
    if (a[31:2] == GPIO_A[31:2])              return K_GPIO;
    if (a[31:2] == TIMER_A[31:2])             return K_TIMER;
    if ({a[31:2], 2'b00} < 32'(depth_of(k) * 4)) return K_RAM;
    return K_UNMAPPED;
  endfunction

  // Monitor: every accept must match the oldest outstanding expectation.
  logic [NI-1:0] prev_acc = '0;
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      if (acc[k]) begin
        check($sformatf("double_accept i%0d", k), 32'(prev_acc[k]), 32'd0);
        if (sb.size() == 0) begin
          check($sformatf("unexpected_accept i%0d", k), 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check($sformatf("accept_inst txn%0d", e.id), 32'(k), 32'(e.inst));
          check($sformatf("latency i%0d txn%0d", k, e.id), 32'(cyc), 32'(e.due));
          if (e.rnw) check($sformatf("rdata i%0d txn%0d", k, e.id), rdata[k], e.data);
        end
      end else begin
        check($sformatf("idle_data i%0d", k), rdata[k], 32'd0);
      end
    end
    prev_acc = acc;
  end

  task automatic issue(input int k, input bit r, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   n, kd, key;
    bit   got;
    valid[k] = 1'b1;
    rnw[k]   = r;
    addr[k]  = a;
    wdata[k] = d;
    n   = (cyc > last_acc[k]) ? cyc : last_acc[k] + 1;
    kd  = kind_of(k, a);
    key = k * 65536 + int'(a[17:2]);
    e.inst = k;
    e.id   = txn_id++;
    e.rnw  = r;
    e.due  = n + 1 + wait_of(k);
    e.data = 32'd0;
    if (r) begin
      case (kd)
        K_RAM:   e.data = ref_ram.exists(key) ? ref_ram[key] : 32'd0;
        K_GPIO:  e.data = ref_gpio[k];
        K_TIMER: e.data = 32'(e.due - rst_cyc);
        default: e.data = 32'd0;
      endcase
    end else begin
      if (kd == K_RAM)  ref_ram[key] = d;
      if (kd == K_GPIO) ref_gpio[k]  = d;
    end
    if (kd == K_UNMAPPED) ref_err[k] = 1'b1;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = acc[k];
    end
    if (!got) check($sformatf("accept_timeout i%0d txn%0d", k, e.id), 32'd0, 32'd1);
    last_acc[k] = cyc;
  endtask

  task automatic drop(input int k);
    valid[k] = 1'b0;
  endtask

  task automatic do_reset(input int n);
    nrst  = 1'b0;
    valid = '0;
    repeat (n) @(posedge clk);
    #1;
    nrst    = 1'b1;
    rst_cyc = cyc;
    for (int k = 0; k < NI; k++) begin
      ref_gpio[k] = '0;
      ref_err[k]  = 1'b0;
      last_acc[k] = -100;
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_accept i%0d", k), 32'(acc[k]), 32'd0);
      check($sformatf("rst_gpio i%0d", k), gpio[k], 32'd0);
      check($sformatf("rst_err i%0d", k), 32'(err[k]), 32'd0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, old_g, v;
    int          kd, key, sel;
    nrst  = 1'b0;
    valid = '0;
    rnw   = '1;
    addr  = '0;
    wdata = '0;
    for (int k = 0; k < NI; k++) last_acc[k] = -100;

    @(posedge clk); #1;
    do_reset(3);

    // First transaction after reset reads a small timer value.
    issue(1, 1'b1, TIMER_A, '0); drop(1);

    // Zero wait states: write then read.
    @(posedge clk); #1;
    issue(0, 1'b0, 32'h10, 32'hDEAD_BEEF); drop(0);
    @(posedge clk); #1;
    issue(0, 1'b1, 32'h10, '0); drop(0);

    // Three wait states: back-to-back writes then reads with valid held high.
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) issue(2, 1'b0, 32'(i * 4), 32'hC0DE_0000 + 32'(i * 17));
    for (int i = 0; i < 8; i++) issue(2, 1'b1, 32'(i * 4), '0);
    drop(2);

    // RAM boundary on the 64-word instance: last word mapped, next one not.
    @(posedge clk); #1;
    issue(2, 1'b0, 32'h0FC, 32'h1234_5678);
    issue(2, 1'b1, 32'h0FC, '0);
    issue(2, 1'b1, 32'h100, '0);
    drop(2);
    @(negedge clk);
    check("err_boundary i2", 32'(err[2]), 32'd1);

    // GPIO write lands on the edge ending the accept cycle.
    @(posedge clk); #1;
    old_g = gpio[1];
    issue(1, 1'b0, GPIO_A, 32'h0000_00A5); drop(1);
    check("gpio_before_commit", gpio[1], old_g);
    @(negedge clk);
    check("gpio_after_commit", gpio[1], 32'h0000_00A5);
    issue(1, 1'b1, GPIO_A, '0);
    issue(1, 1'b1, GPIO_A | 32'h3, '0);
    issue(1, 1'b0, TIMER_A, 32'h0000_0000);
    issue(1, 1'b1, TIMER_A, '0);
    drop(1);

    // Unmapped access is accepted, reads zero, sets a sticky error.
    @(posedge clk); #1;
    check("err_pre_unmapped i1", 32'(err[1]), 32'd0);
    issue(1, 1'b1, 32'h4000_0000, '0); drop(1);
    @(negedge clk);
    check("err_set i1", 32'(err[1]), 32'd1);
    issue(1, 1'b0, 32'h40, 32'h5555_AAAA); drop(1);
    @(negedge clk);
    check("err_sticky i1", 32'(err[1]), 32'd1);

    // Randomized mix per instance.
    for (int k = 0; k < NI; k++) begin
      @(posedge clk); #1;
      for (int t = 0; t < 30; t++) begin
        sel = int'($urandom_range(0, 9));
        if (sel <= 5)      a = 32'($urandom_range(0, 15) * 4);
        else if (sel == 6) a = GPIO_A;
        else if (sel == 7) a = TIMER_A;
        else if (sel == 8) a = 32'(depth_of(k) * 4) + 32'($urandom_range(0, 63) * 4);
        else               a = 32'((depth_of(k) - 1) * 4);
        kd  = kind_of(k, a);
        key = k * 65536 + int'(a[17:2]);
        v   = $urandom;
        if (kd == K_RAM && !ref_ram.exists(key)) issue(k, 1'b0, a, v);
        else                                     issue(k, 1'($urandom_range(0, 1)), a, v);
        if ($urandom_range(0, 1) == 1) begin
          drop(k);
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
      drop(k);
      @(negedge clk);
      check($sformatf("rand_err i%0d", k), 32'(err[k]), 32'(ref_err[k]));
      check($sformatf("rand_gpio i%0d", k), gpio[k], ref_gpio[k]);
    end

    // Reset caught during the wait states of a write abandons it.
    @(posedge clk); #1;
    issue(2, 1'b0, 32'h20, 32'h1111_2222); drop(2);
    @(posedge clk); #1;
    valid[2] = 1'b1;
    rnw[2]   = 1'b0;
    addr[2]  = 32'h20;
    wdata[2] = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset(2);
    issue(2, 1'b1, 32'h20, '0); drop(2);
    issue(1, 1'b1, GPIO_A, '0); drop(1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
